// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - boot-time program loader: UART bytes -> 32-bit memory words
//
// Purpose:
//   Collects bytes from the UART byte receiver and writes them into
//   instruction/data memory. The stream is a 4-byte big-endian word count
//   followed by that many 32-bit big-endian words. Completion or failure is
//   reported to the boot/reset logic through sticky done/err flags.
//
// Configuration:
//   UART_LOADER_CHECKSUM_EN - when defined, one trailing checksum byte is
//   expected after the last word (or after a zero-count header). It must
//   equal the XOR of every header and data byte of the load; a mismatch
//   ends the load in the error state.
//
// Ports:
//   CLK        in   system clock, all logic on posedge
//   RST_N      in   synchronous reset, active-low
//   start      in   arms the loader when seen high in IDLE, DONE or ERR
//   rx_data    in   [7:0] received byte, qualified by rx_valid
//   rx_valid   in   1-cycle strobe per received byte
//   mem_we     out  1-cycle memory write enable
//   mem_addr   out  [ADDR_WIDTH-1:0] word write address
//   mem_wdata  out  [31:0] word write data
//   busy       out  high from accepted start until DONE/ERR
//   done       out  sticky, load completed successfully
//   err        out  sticky, load aborted

module uart_loader #(
  parameter int ADDR_WIDTH = 14,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = 16384
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_FINISH,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [31:0]           MAX_CNT = 32'(MAX_WORDS);

  state_t      state;
  logic [1:0]  byte_idx;

  // Holds the header count while it is being received, then serves as the
  // remaining-word counter for the data phase.
  logic [31:0] count_q;

  // Only the first three bytes of a word need storing: the fourth byte goes
  // straight into mem_wdata together with these.
  logic [23:0] word_q;

`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q;
`endif

  logic [31:0] count_next;
  logic [31:0] word_next;

  assign count_next = {count_q[23:0], rx_data};
  assign word_next  = {word_q, rx_data};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      byte_idx  <= 2'd0;
      count_q   <= 32'd0;
      word_q    <= 24'd0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      xor_q     <= 8'd0;
`endif
    end else begin
      mem_we <= 1'b0;

      // The write cycle itself advances the address and the remaining count,
      // independent of state, so a byte arriving in this cycle is free to
      // start the next word.
      if (mem_we) begin
        mem_addr <= mem_addr + ADDR_WIDTH'(1);
        count_q  <= count_q - 32'd1;
      end

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          // A byte coinciding with start is deliberately dropped here.
          if (start) begin
            state    <= S_HEADER;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            byte_idx <= 2'd0;
            count_q  <= 32'd0;
            word_q   <= 24'd0;
            mem_addr <= BASE;
`ifdef UART_LOADER_CHECKSUM_EN
            xor_q    <= 8'd0;
`endif
          end
        end

        S_HEADER: begin
          if (rx_valid) begin
            count_q  <= count_next;
            byte_idx <= byte_idx + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
            xor_q    <= xor_q ^ rx_data;
`endif
            if (byte_idx == 2'd3) begin
              if (count_next == 32'd0) begin
                state <= S_FINISH;
              end else if (count_next > MAX_CNT) begin
                state <= S_ERR;
                busy  <= 1'b0;
                err   <= 1'b1;
              end else begin
                state <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            word_q   <= word_next[23:0];
            byte_idx <= byte_idx + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
            xor_q    <= xor_q ^ rx_data;
`endif
            if (byte_idx == 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= word_next;
              // count_q still includes the word being completed; it is
              // decremented during the write cycle that follows.
              if (count_q == 32'd1) begin
                state <= S_FINISH;
              end
            end
          end
        end

        S_FINISH: begin
`ifdef UART_LOADER_CHECKSUM_EN
          // The checksum byte may arrive during the final write cycle.
          if (rx_valid) begin
            busy <= 1'b0;
            if (rx_data == xor_q) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
`else
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
`endif
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - self-checking bench for uart_loader

module tb_uart_loader;

  localparam int AW   = 14;
  localparam int BASE = 0;
  localparam int MAXW = 16384;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam bit CK       = 1'b1;
  localparam int DONE_LAT = 0;
`else
  localparam bit CK       = 1'b0;
  localparam int DONE_LAT = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err;

  uart_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          c;
  } wr_t;

  wr_t         got[$];
  logic [31:0] wq[$];
  logic        done_d = 1'b0;
  logic        err_d = 1'b0;
  int          done_cyc = -1;
  int          err_cyc = -1;
  int          n_cmp = 0;
  int          n_fail = 0;

  always @(negedge CLK) begin
    if (mem_we === 1'b1) got.push_back('{int'(mem_addr), mem_wdata, cyc});
    if (done === 1'b1 && done_d !== 1'b1) done_cyc = cyc;
    if (err === 1'b1 && err_d !== 1'b1) err_cyc = cyc;
    done_d = done;
    err_d  = err;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit st, output int c);
    idle(gap);
    rx_data  = b;
    rx_valid = 1'b1;
    start    = st;
    @(posedge CLK);
    #1;
    c        = cyc;
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Full load: header hdr, words from wq, optional checksum. The model states
  // what must come out: word i at BASE+i one cycle after its last byte, and
  // the done/err outcome with its timing.
  task automatic do_load(input logic [31:0] hdr, input int gap_max,
                         input bit bad_ck, input bit noise);
    logic [7:0] bq[$];
    int         lastc[$];
    int         nexp, c, last_c;
    bit         legal, exp_err;
    logic [7:0] x;
    logic [31:0] w;
    legal = (hdr <= MAXW);
    nexp  = legal ? int'(hdr) : 0;
    bq = {hdr[31:24], hdr[23:16], hdr[15:8], hdr[7:0]};
    for (int i = 0; i < nexp; i++) begin
      w = wq[i];
      bq.push_back(w[31:24]); bq.push_back(w[23:16]);
      bq.push_back(w[15:8]);  bq.push_back(w[7:0]);
    end
    x = 8'h00;
    foreach (bq[i]) x ^= bq[i];
    got.delete();
    done_cyc = -1;
    err_cyc  = -1;
    last_c   = 0;

    start    = 1'b1;
    rx_valid = noise;
    rx_data  = 8'($urandom);
    @(posedge CLK);
    #1;
    start    = 1'b0;
    rx_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL start_arm: busy/done/err=%b%b%b want 100", busy, done, err);
    end

    for (int i = 0; i < bq.size(); i++) begin
      send_byte(bq[i], $urandom_range(0, gap_max),
                noise && (i != bq.size() - 1) && ($urandom_range(0, 2) == 0), c);
      if (i >= 4 && ((i - 4) % 4) == 3) lastc.push_back(c);
      last_c = c;
    end
    if (CK && legal) begin
      send_byte(bad_ck ? (x ^ 8'hA5) : x, $urandom_range(0, gap_max), 1'b0, c);
      last_c = c;
    end
    idle(4);

    exp_err = !legal || (CK && bad_ck);
    n_cmp++;
    if (got.size() != nexp) begin
      n_fail++;
      $display("FAIL write_count: got %0d want %0d", got.size(), nexp);
    end
    for (int i = 0; i < nexp && i < got.size(); i++) begin
      n_cmp++;
      if (got[i].addr != ((BASE + i) % (1 << AW)) || got[i].data !== wq[i] || got[i].c != lastc[i]) begin
        n_fail++;
        $display("FAIL write_%0d: addr %0d data %h cyc %0d want addr %0d data %h cyc %0d",
                 i, got[i].addr, got[i].data, got[i].c, (BASE + i) % (1 << AW), wq[i], lastc[i]);
      end
    end
    n_cmp++;
    if (done !== !exp_err || err !== exp_err || busy !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL end_flags: done/err/busy=%b%b%b want %b%b0", done, err, busy, !exp_err, exp_err);
    end
    n_cmp++;
    if (exp_err ? (err_cyc != last_c) : (done_cyc != last_c + DONE_LAT)) begin
      n_fail++;
      $display("FAIL end_latency: done_cyc %0d err_cyc %0d last byte cyc %0d", done_cyc, err_cyc, last_c);
    end
  endtask

  task automatic test_reset();
    int c;
    RST_N = 1'b0;
    idle(2);
    n_cmp++;
    if (mem_we !== 1'b0 || mem_addr !== AW'(BASE) || mem_wdata !== 32'd0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: we %b addr %h wdata %h busy %b done %b err %b",
               mem_we, mem_addr, mem_wdata, busy, done, err);
    end
    RST_N = 1'b1;
    got.delete();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0, 1'b0, c);
    idle(3);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || got.size() != 0) begin
      n_fail++;
      $display("FAIL idle_ignores_bytes: busy %b done %b writes %0d want 0 0 0", busy, done, got.size());
    end
  endtask

  task automatic test_basic();
    wq = {32'hDEADBEEF, 32'h01234567};
    do_load(32'd2, 0, 1'b0, 1'b0);
    do_load(32'd2, 3, 1'b0, 1'b0);
  endtask

  task automatic test_zero_count();
    wq.delete();
    do_load(32'd0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_over_max();
    wq.delete();
    do_load(32'h00010000, 1, 1'b0, 1'b0);
    do_load(32'(MAXW + 1), 0, 1'b0, 1'b0);
    wq = {32'hCAFEF00D};
    do_load(32'd1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back($urandom);
    do_load(32'd3, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 6);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      do_load(32'(n), $urandom_range(0, 3), 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset_midload();
    int c;
    logic [7:0] hb[4];
    hb = '{8'h00, 8'h00, 8'h00, 8'h02};
    start = 1'b1;
    idle(1);
    start = 1'b0;
    got.delete();
    for (int i = 0; i < 4; i++) send_byte(hb[i], 0, 1'b0, c);
    send_byte(8'h11, 1, 1'b0, c);
    send_byte(8'h22, 0, 1'b0, c);
    RST_N = 1'b0;
    idle(2);
    RST_N = 1'b1;
    idle(4);
    n_cmp++;
    if (got.size() != 0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || mem_addr !== AW'(BASE)) begin
      n_fail++;
      $display("FAIL reset_midload: writes %0d busy %b done %b err %b addr %h",
               got.size(), busy, done, err, mem_addr);
    end
    wq = {32'h89ABCDEF, 32'h76543210};
    do_load(32'd2, 1, 1'b0, 1'b0);
    if (CK) do_load(32'd2, 1, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_over_max();
    test_back_to_back();
    test_random();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
